// File: rtl/fsk_demodulator.sv
// FSK demodulator: measures spacing between rising edges of a synchronized square
// wave, classifies each spacing as mark/space and debounces the result into a bit.
module fsk_demodulator #(
  parameter int CNT_W      = 16,
  parameter int MIN_PERIOD = 8,
  parameter int THRESH     = 1000,
  parameter int TIMEOUT    = 4000,
  parameter int CONFIRM    = 2
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             signal_in,
  output logic             signal_out,
  output logic             carrier_detect,
  output logic [CNT_W-1:0] period_out
);

  localparam int CONF_W = $clog2(CONFIRM + 1);
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]  THRESH_C  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CONF_W-1:0] CONFIRM_C = CONF_W'(CONFIRM);

  typedef enum logic [1:0] {
    NO_CARRIER = 2'd0,
    ACQUIRE    = 2'd1,
    LOCKED     = 2'd2
  } state_t;

  state_t              state;
  logic                sync_p0;
  logic                sync_p1;
  logic                prev_p2;
  logic [CNT_W-1:0]    cnt;
  logic                cand;
  logic [CONF_W-1:0]   conf;

  logic                rise;
  logic                in_carrier;
  logic                accept;
  logic                cls;
  logic                confirmed;
  logic                timeout;
  logic [CONF_W-1:0]   conf_next;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (v >= TIMEOUT_C) ? TIMEOUT_C : v + 1'b1;
  endfunction

  function automatic logic [CONF_W-1:0] sat_conf(input logic [CONF_W-1:0] v);
    return (v >= CONFIRM_C) ? CONFIRM_C : v + 1'b1;
  endfunction

  // Edge-detect / classification stage: decisions for the current cycle
  always_comb begin
    rise       = sync_p1 & ~prev_p2;
    in_carrier = (state != NO_CARRIER);
    accept     = rise & (~in_carrier | (cnt >= MIN_C));
    cls        = (cnt < THRESH_C);
    conf_next  = (cls == cand) ? sat_conf(conf) : CONF_W'(1);
    confirmed  = accept & in_carrier & (conf_next == CONFIRM_C);
    timeout    = in_carrier & ~accept & (cnt == TIMEOUT_C);
  end

  // Register stage: synchronizer, period counter, state machine and outputs
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_p0        <= 1'b0;
      sync_p1        <= 1'b0;
      prev_p2        <= 1'b0;
      cnt            <= '0;
      state          <= NO_CARRIER;
      cand           <= 1'b0;
      conf           <= '0;
      signal_out     <= 1'b1;
      carrier_detect <= 1'b0;
      period_out     <= '0;
    end else begin
      sync_p0 <= signal_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      cnt     <= accept ? CNT_W'(1) : sat_cnt(cnt);
      case (state)
        NO_CARRIER: begin
          if (accept) state <= ACQUIRE;
        end
        ACQUIRE, LOCKED: begin
          if (accept) begin
            period_out <= cnt;
            cand       <= cls;
            conf       <= conf_next;
            if (confirmed) begin
              signal_out     <= cls;
              carrier_detect <= 1'b1;
              state          <= LOCKED;
            end
          end else if (timeout) begin
            state          <= NO_CARRIER;
            signal_out     <= 1'b1;
            carrier_detect <= 1'b0;
            cand           <= 1'b0;
            conf           <= '0;
          end
        end
        default: state <= NO_CARRIER;
      endcase
    end
  end

endmodule
